// File: rtl/ball_pkg.sv
// Shared encodings for the ball motion controller.
// State machine states and axis direction values.
package ball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MANUAL,
    ST_AUTO
  } state_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/tick_gen.sv
// Move-rate divider: pulses tick once every TICK_DIV enabled cycles.
// en=0 freezes the phase, clr returns the count to zero.
module tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position controller: manual button moves or autonomous bounce,
// rate-divided by tick_gen and clamped to the visible area.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BALL_SIZE = 16,
  parameter int STEP      = 1,
  parameter int TICK_DIV  = 1,
  parameter int X_W       = 10,
  parameter int Y_W       = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic           pause,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  output logic [X_W-1:0] ballX,
  output logic [Y_W-1:0] ballY,
  output logic           dirX,
  output logic           dirY,
  output logic           hit_x,
  output logic           hit_y
);

  localparam int X_MAX = H_RES - BALL_SIZE;
  localparam int Y_MAX = V_RES - BALL_SIZE;
  localparam logic signed [X_W:0] XMAX_S = (X_W+1)'(X_MAX);
  localparam logic signed [Y_W:0] YMAX_S = (Y_W+1)'(Y_MAX);
  localparam logic signed [X_W:0] XSTEP  = (X_W+1)'(STEP);
  localparam logic signed [Y_W:0] YSTEP  = (Y_W+1)'(STEP);

  state_t state;
  logic   tick;
  logic   tg_en;
  logic   tg_clr;

  assign tg_en  = (state != ST_IDLE) && !pause;
  assign tg_clr = (state == ST_IDLE);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (tg_en),
    .clr (tg_clr),
    .tick(tick)
  );

  logic signed [X_W:0] xs, xm;
  logic signed [Y_W:0] ys, ym;
  logic                bx, by;

  // Touching a wall in auto mode counts as a bounce.
  always_comb begin
    xs = $signed({1'b0, ballX});
    ys = $signed({1'b0, ballY});
    xm = xs;
    ym = ys;
    bx = 1'b0;
    by = 1'b0;
    if (state == ST_AUTO) begin
      xm = (dirX == DIR_POS) ? xs + XSTEP : xs - XSTEP;
      ym = (dirY == DIR_POS) ? ys + YSTEP : ys - YSTEP;
      if (dirX == DIR_POS && xm >= XMAX_S) begin
        xm = XMAX_S;
        bx = 1'b1;
      end else if (dirX == DIR_NEG && xm <= 0) begin
        xm = '0;
        bx = 1'b1;
      end
      if (dirY == DIR_POS && ym >= YMAX_S) begin
        ym = YMAX_S;
        by = 1'b1;
      end else if (dirY == DIR_NEG && ym <= 0) begin
        ym = '0;
        by = 1'b1;
      end
    end else begin
      if (right && !left) xm = xs + XSTEP;
      else if (left && !right) xm = xs - XSTEP;
      if (down && !up) ym = ys + YSTEP;
      else if (up && !down) ym = ys - YSTEP;
      if (xm > XMAX_S) xm = XMAX_S;
      else if (xm < 0) xm = '0;
      if (ym > YMAX_S) ym = YMAX_S;
      else if (ym < 0) ym = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ballX <= X_W'(X_MAX / 2);
      ballY <= Y_W'(Y_MAX / 2);
      dirX  <= DIR_POS;
      dirY  <= DIR_POS;
      hit_x <= 1'b0;
      hit_y <= 1'b0;
    end else begin
      hit_x <= 1'b0;
      hit_y <= 1'b0;
      unique case (state)
        ST_IDLE:   if (start) state <= mode ? ST_AUTO : ST_MANUAL;
        ST_MANUAL: if (mode) state <= ST_AUTO;
        ST_AUTO:   if (!mode) state <= ST_MANUAL;
        default:   state <= ST_IDLE;
      endcase
      if (tick && state != ST_IDLE) begin
        ballX <= xm[X_W-1:0];
        ballY <= ym[Y_W-1:0];
        if (bx) begin
          dirX  <= ~dirX;
          hit_x <= 1'b1;
        end
        if (by) begin
          dirY  <= ~dirY;
          hit_y <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl with TICK_DIV=4, STEP=2.
// Vector table for the main walk plus hand sequences for pause/reset.
module tb_ball_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, mode, pause;
  logic       up, down, left, right;
  logic [9:0] ballX;
  logic [8:0] ballY;
  logic       dirX, dirY, hit_x, hit_y;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl #(
    .H_RES(640), .V_RES(480), .BALL_SIZE(16),
    .STEP(2), .TICK_DIV(4), .X_W(10), .Y_W(9)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pause(pause),
    .up(up), .down(down), .left(left), .right(right),
    .ballX(ballX), .ballY(ballY), .dirX(dirX), .dirY(dirY),
    .hit_x(hit_x), .hit_y(hit_y)
  );

  typedef struct {
    logic m, u, d, l, r;
    int   ncyc;
    int   x, y;
    logic dx, dy, hx, hy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic m, u, d, l, r, input int ncyc,
                     input int x, y, input logic dx, dy, hx, hy);
    vec_t v;
    v = '{m, u, d, l, r, ncyc, x, y, dx, dy, hx, hy};
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string nm, input int x, y,
                         input logic dx, dy, hx, hy);
    chk({nm, ".x"}, int'(ballX), x);
    chk({nm, ".y"}, int'(ballY), y);
    chk({nm, ".dx"}, int'(dirX), int'(dx));
    chk({nm, ".dy"}, int'(dirY), int'(dy));
    chk({nm, ".hx"}, int'(hit_x), int'(hx));
    chk({nm, ".hy"}, int'(hit_y), int'(hy));
  endtask

  initial begin
    rst = 1'b1; start = 0; mode = 0; pause = 0;
    up = 0; down = 0; left = 0; right = 0;

    // manual walk: mode,u,d,l,r, cycles, x,y, dx,dy, hx,hy
    add(0, 1, 1, 0, 0,   4, 316, 232, 1, 1, 0, 0);
    add(0, 1, 1, 0, 1,   4, 318, 232, 1, 1, 0, 0);
    add(0, 0, 1, 1, 1,   4, 318, 234, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0,  20, 318, 244, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0,  24, 318, 232, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 632,   2, 232, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0,   4,   0, 232, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0,   4,   0, 232, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0,   4,   0, 232, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1,1244, 622, 232, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1,   4, 624, 232, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1,   4, 624, 232, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0,   4, 622, 232, 1, 1, 0, 0);
    // auto right-wall bounce, pulse lasts one cycle
    add(1, 0, 0, 0, 0,   4, 624, 234, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0,   1, 624, 234, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0,   3, 622, 236, 0, 1, 0, 0);
    // back to manual to set up the corner
    add(0, 0, 1, 1, 0, 452, 396, 462, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 788,   2, 462, 0, 1, 0, 0);
    // auto corner: both axes bounce together
    add(1, 0, 0, 0, 0,   4,   0, 464, 1, 0, 1, 1);
    add(1, 0, 0, 0, 0,   1,   0, 464, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0,   3,   2, 462, 1, 0, 0, 0);

    step(3);
    chk_all("rst", 312, 232, 1, 1, 0, 0);
    rst = 1'b0;
    right = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle.x", int'(ballX), 312);
      chk("idle.y", int'(ballY), 232);
    end

    start = 1'b1;
    step(5);
    chk("first.x", int'(ballX), 314);
    step(4);
    chk_all("second", 316, 232, 1, 1, 0, 0);

    foreach (vq[i]) begin
      mode = vq[i].m; up = vq[i].u; down = vq[i].d;
      left = vq[i].l; right = vq[i].r;
      step(vq[i].ncyc);
      chk_all($sformatf("vec%0d", i), vq[i].x, vq[i].y,
              vq[i].dx, vq[i].dy, vq[i].hx, vq[i].hy);
    end

    // pause mid-count: counter sits at 2 while frozen
    step(2);
    chk("prepause.x", int'(ballX), 2);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("pause.x", int'(ballX), 2);
      chk("pause.y", int'(ballY), 462);
    end
    pause = 1'b0;
    step(1);
    chk("resume1.x", int'(ballX), 2);
    step(1);
    chk_all("resume2", 4, 460, 1, 0, 0, 0);

    // asynchronous reset mid-count
    step(2);
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk_all("midrst", 312, 232, 1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(8);
    chk("postrst.x", int'(ballX), 312);
    chk("postrst.y", int'(ballY), 232);

    // start straight into auto from centre
    start = 1'b1;
    step(5);
    chk_all("autostart", 314, 234, 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
